mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: round-robin grant, fixed 3-cycle access.
// Owner registers capture the winning request so the access ignores late input changes.
module mem_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_,
    input  logic          req_0,
    input  logic          wr_0,
    input  logic [AW-1:0] addr_0,
    input  logic [DW-1:0] wdata_0,
    input  logic          req_1,
    input  logic          wr_1,
    input  logic [AW-1:0] addr_1,
    input  logic [DW-1:0] wdata_1,
    output logic          gnt_0,
    output logic          gnt_1,
    output logic          ack_0,
    output logic          ack_1,
    output logic [DW-1:0] rdata,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t        state;
    logic          own;
    logic          own_wr;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          last;

    logic          win;
    logic          sel_wr;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;

    // Pick a winner: a sole requester wins, a tie goes to whoever lost last time
    always_comb begin
        win = req_1;
        if (req_0 && req_1) begin
            win = ~last;
        end
        sel_wr    = win ? wr_1    : wr_0;
        sel_addr  = win ? addr_1  : addr_0;
        sel_wdata = win ? wdata_1 : wdata_0;
    end

    // Access sequencer: capture owner in IDLE, strobe memory in ADDR/DATA
    always_ff @(posedge clk or posedge rst_) begin
        if (rst_) begin
            state     <= IDLE;
            own       <= 1'b0;
            own_wr    <= 1'b0;
            own_addr  <= '0;
            own_wdata <= '0;
            last      <= 1'b1;
            gnt_0     <= 1'b0;
            gnt_1     <= 1'b0;
            ack_0     <= 1'b0;
            ack_1     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_0 || req_1) begin
                        state     <= ADDR;
                        own       <= win;
                        own_wr    <= sel_wr;
                        own_addr  <= sel_addr;
                        own_wdata <= sel_wdata;
                        last      <= win;
                        gnt_0     <= ~win;
                        gnt_1     <= win;
                        mem_rd    <= ~sel_wr;
                        busy      <= 1'b1;
                    end
                end
                ADDR: begin
                    state  <= DATA;
                    mem_wr <= own_wr;
                    ack_0  <= ~own;
                    ack_1  <= own;
                end
                DATA: begin
                    state  <= IDLE;
                    gnt_0  <= 1'b0;
                    gnt_1  <= 1'b0;
                    ack_0  <= 1'b0;
                    ack_1  <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    busy   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Address/data buses are quiet outside an access
    assign mem_addr  = busy ? own_addr  : '0;
    assign mem_wdata = busy ? own_wdata : '0;

    // Read data only passes through during the acknowledging cycle of a read
    assign rdata = ((ack_0 || ack_1) && !own_wr) ? mem_rdata : '0;

endmodule
